// File: rtl/snake_collision_sched.sv
// Sequential head-vs-body collision scan for the two-snake game core.
// Define SNAKE_SELF_COLLISION_EN to also check each head against its own body.
module snake_collision_sched #(
   parameter int MAX_SEG = 16,
   parameter int SEG_W   = 16,
   parameter int POS_W   = 10,
   parameter int LEN_W   = 5
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     start,
   input  logic                     clear,
   input  logic [LEN_W-1:0]         len1,
   input  logic [LEN_W-1:0]         len2,
   input  logic [MAX_SEG*SEG_W-1:0] snake1,
   input  logic [MAX_SEG*SEG_W-1:0] snake2,
   output logic                     busy,
   output logic                     done,
   output logic                     should_stop1,
   output logic                     should_stop2
);

   localparam int CNT_W = $clog2(MAX_SEG + 1);
   localparam int IDX_W = (MAX_SEG > 1) ? $clog2(MAX_SEG) : 1;

   typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

   state_t             state_q, state_d;
   logic [IDX_W-1:0]   i_q, i_d;
   logic [CNT_W-1:0]   l1_q, l1_d;
   logic [CNT_W-1:0]   l2_q, l2_d;
   logic [CNT_W-1:0]   n_q, n_d;
   logic               p1_q, p1_d;
   logic               p2_q, p2_d;
   logic               stop1_q, stop1_d;
   logic               stop2_q, stop2_d;
   logic [POS_W-1:0]   pos1_q [MAX_SEG];
   logic [POS_W-1:0]   pos1_d [MAX_SEG];
   logic [POS_W-1:0]   pos2_q [MAX_SEG];
   logic [POS_W-1:0]   pos2_d [MAX_SEG];

   logic [CNT_W-1:0]   lc1, lc2, nc;
   logic [CNT_W-1:0]   i_ext;
   logic               hit1, hit2, last;
   logic               unused_hi;

   // Only the position field of each slot matters to the scan.
   assign unused_hi = ^{snake1, snake2};

   always_comb begin
      lc1 = (32'(len1) > MAX_SEG) ? CNT_W'(MAX_SEG) : CNT_W'(len1);
      lc2 = (32'(len2) > MAX_SEG) ? CNT_W'(MAX_SEG) : CNT_W'(len2);
      nc  = (lc1 > lc2) ? lc1 : lc2;
   end

   assign i_ext = CNT_W'(i_q);
   assign last  = (i_ext == n_q - CNT_W'(1));

`ifdef SNAKE_SELF_COLLISION_EN
   always_comb begin
      hit1 = ((i_ext < l2_q) && (pos1_q[0] == pos2_q[i_q])) ||
             ((i_q != '0) && (i_ext < l1_q) &&
              (pos1_q[0] == pos1_q[i_q]));
      hit2 = ((i_ext < l1_q) && (pos2_q[0] == pos1_q[i_q])) ||
             ((i_q != '0) && (i_ext < l2_q) &&
              (pos2_q[0] == pos2_q[i_q]));
   end
`else
   always_comb begin
      hit1 = (i_ext < l2_q) && (pos1_q[0] == pos2_q[i_q]);
      hit2 = (i_ext < l1_q) && (pos2_q[0] == pos1_q[i_q]);
   end
`endif

   always_comb begin
      state_d = state_q;
      i_d     = i_q;
      l1_d    = l1_q;
      l2_d    = l2_q;
      n_d     = n_q;
      p1_d    = p1_q;
      p2_d    = p2_q;
      stop1_d = stop1_q;
      stop2_d = stop2_q;
      pos1_d  = pos1_q;
      pos2_d  = pos2_q;
      unique case (state_q)
         IDLE: begin
            if (start) begin
               for (int k = 0; k < MAX_SEG; k++) begin
                  pos1_d[k] = snake1[k*SEG_W +: POS_W];
                  pos2_d[k] = snake2[k*SEG_W +: POS_W];
               end
               l1_d    = lc1;
               l2_d    = lc2;
               n_d     = nc;
               i_d     = '0;
               p1_d    = 1'b0;
               p2_d    = 1'b0;
               state_d = (nc == '0) ? DONE : SCAN;
            end
         end
         SCAN: begin
            p1_d = p1_q | hit1;
            p2_d = p2_q | hit2;
            if (last) begin
               // Fold in this cycle's hit so the flags land with done.
               stop1_d = stop1_q | p1_q | hit1;
               stop2_d = stop2_q | p2_q | hit2;
               state_d = DONE;
            end else begin
               i_d = i_q + IDX_W'(1);
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
      if (clear) begin
         state_d = IDLE;
         i_d     = '0;
         p1_d    = 1'b0;
         p2_d    = 1'b0;
         stop1_d = 1'b0;
         stop2_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         i_q     <= '0;
         l1_q    <= '0;
         l2_q    <= '0;
         n_q     <= '0;
         p1_q    <= 1'b0;
         p2_q    <= 1'b0;
         stop1_q <= 1'b0;
         stop2_q <= 1'b0;
      end else begin
         state_q <= state_d;
         i_q     <= i_d;
         l1_q    <= l1_d;
         l2_q    <= l2_d;
         n_q     <= n_d;
         p1_q    <= p1_d;
         p2_q    <= p2_d;
         stop1_q <= stop1_d;
         stop2_q <= stop2_d;
      end
   end

   always_ff @(posedge clk) begin
      pos1_q <= pos1_d;
      pos2_q <= pos2_d;
   end

   assign busy         = (state_q == SCAN);
   assign done         = (state_q == DONE);
   assign should_stop1 = stop1_q;
   assign should_stop2 = stop2_q;

endmodule

// File: tb/tb_snake_collision_sched.sv
// Directed bench for snake_collision_sched: latency, flags, clear, clamp.
module tb_snake_collision_sched;

   logic         clk = 1'b0;
   logic         rst, start, clear;
   logic [4:0]   len1, len2;
   logic [255:0] snake1, snake2;
   logic         busy, done, should_stop1, should_stop2;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   snake_collision_sched dut (
      .clk          (clk),
      .rst          (rst),
      .start        (start),
      .clear        (clear),
      .len1         (len1),
      .len2         (len2),
      .snake1       (snake1),
      .snake2       (snake2),
      .busy         (busy),
      .done         (done),
      .should_stop1 (should_stop1),
      .should_stop2 (should_stop2)
   );

   task automatic chk(input string tag, input int got, input int exp);
      n_cmp++;
      if (got != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   task automatic put(input int s, input int k, input logic [15:0] v);
      if (s == 1) snake1[k*16 +: 16] = v;
      else        snake2[k*16 +: 16] = v;
   endtask

   task automatic do_clear;
      clear = 1'b1;
      step;
      clear = 1'b0;
   endtask

   // mode 1: mid-scan start re-pulse plus snake2 rewrite
   task automatic scan(input string tag, input int exp_n,
                       input int exp_s1, input int exp_s2,
                       input int mode);
      int nb;
      int k;
      start = 1'b1;
      step;
      start = 1'b0;
      nb = 0;
      k  = 0;
      while (!done && k < 40) begin
         if (busy) nb++;
         if (mode == 1 && k == 1) begin
            start  = 1'b1;
            snake2 = '0;
            for (int j = 0; j < 4; j++) put(2, j, 16'(40 + j));
         end
         if (mode == 1 && k == 2) start = 1'b0;
         step;
         k++;
      end
      chk({tag, "_lat"}, k, exp_n);
      chk({tag, "_busy"}, nb, exp_n);
      chk({tag, "_s1"}, int'(should_stop1), exp_s1);
      chk({tag, "_s2"}, int'(should_stop2), exp_s2);
      step;
      chk({tag, "_idle"}, int'({busy, done}), 0);
   endtask

   task automatic set_apart;
      snake1 = '0; snake2 = '0;
      len1 = 5'd3; len2 = 5'd3;
      put(1, 0, 16'd5);  put(1, 1, 16'd4);  put(1, 2, 16'd3);
      put(2, 0, 16'd20); put(2, 1, 16'd21); put(2, 2, 16'd22);
   endtask

   task automatic set_body;
      snake1 = '0; snake2 = '0;
      len1 = 5'd2; len2 = 5'd4;
      put(1, 0, 16'd7);  put(1, 1, 16'd8);
      put(2, 0, 16'd30); put(2, 1, 16'd31);
      put(2, 2, 16'd7);  put(2, 3, 16'd33);
   endtask

   initial begin
      int nd;
      int exp_self;
      rst = 1'b1; start = 1'b0; clear = 1'b0;
      len1 = '0; len2 = '0; snake1 = '0; snake2 = '0;
      step; step;
      rst = 1'b0;
      step;
      chk("rst_busy", int'(busy), 0);
      chk("rst_done", int'(done), 0);
      chk("rst_s1", int'(should_stop1), 0);
      chk("rst_s2", int'(should_stop2), 0);

      set_apart;
      scan("apart", 3, 0, 0, 0);

      set_body;
      scan("body", 4, 1, 0, 0);
      set_apart;
      scan("sticky", 3, 1, 0, 0);
      do_clear;
      chk("clr_s1", int'(should_stop1), 0);
      chk("clr_s2", int'(should_stop2), 0);

      snake1 = '0; snake2 = '0;
      len1 = 5'd1; len2 = 5'd1;
      put(1, 0, 16'd12); put(2, 0, 16'd12);
      scan("headon", 1, 1, 1, 0);

      len1 = 5'd0; len2 = 5'd0;
      scan("n0", 0, 1, 1, 0);

      set_body;
      start = 1'b1;
      step;
      start = 1'b0;
      step;
      clear = 1'b1;
      step;
      clear = 1'b0;
      chk("abort_busy", int'(busy), 0);
      chk("abort_done", int'(done), 0);
      chk("abort_s1", int'(should_stop1), 0);
      chk("abort_s2", int'(should_stop2), 0);
      nd = 0;
      for (int j = 0; j < 6; j++) begin
         if (done || busy) nd++;
         step;
      end
      chk("abort_quiet", nd, 0);

      set_body;
      scan("midscan", 4, 1, 0, 1);
      do_clear;

      snake1 = '0; snake2 = '0;
      for (int j = 0; j < 16; j++) put(1, j, 16'(100 + j));
      len1 = 5'd31; len2 = 5'd0;
      scan("clamp", 16, 0, 0, 0);

      snake1 = '0; snake2 = '0;
      len1 = 5'd3; len2 = 5'd1;
      put(1, 0, 16'd9); put(1, 1, 16'd10); put(1, 2, 16'd9);
      put(2, 0, 16'd50);
`ifdef SNAKE_SELF_COLLISION_EN
      exp_self = 1;
`else
      exp_self = 0;
`endif
      scan("self", 3, exp_self, 0, 0);
      do_clear;

      snake1 = '0; snake2 = '0;
      len1 = 5'd1; len2 = 5'd2;
      put(1, 0, 16'h0405);
      put(2, 0, 16'h0020); put(2, 1, 16'h0005);
      scan("mask", 2, 1, 0, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/snake_collision_sched.md
# snake_collision_sched

Sequential collision scheduler for the two-snake game core. On each game tick it snapshots both snakes' segment arrays and lengths, then walks the segment index with one shared comparator pair per snake, one index per cycle. It checks each head against the other snake's body and accumulates hits into sticky stop flags that the movement logic reads. It sits between the snake position registers and the game-state/movement control, and is started by the game tick.

## Interface
- `MAX_SEG`, 16: maximum segments per snake.
- `SEG_W`, 16: bits per segment slot in the packed arrays.
- `POS_W`, 10: position bits, the low bits of each slot, that are compared.
- `LEN_W`, 5: width of the length inputs.
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  request a scan; accepted only in IDLE.
- `clear`  in  1  synchronous clear of stop flags and abort of any scan (new game).
- `len1`  in  LEN_W  active segment count of snake 1 (slot 0 = head).
- `len2`  in  LEN_W  active segment count of snake 2.
- `snake1`  in  MAX_SEG*SEG_W  packed segments; slot i = bits [i*SEG_W +: SEG_W].
- `snake2`  in  MAX_SEG*SEG_W  same layout as `snake1`.
- `busy`  out  1  high while in SCAN.
- `done`  out  1  one-cycle pulse when a scan completes.
- `should_stop1`  out  1  sticky: snake 1 head hit something.
- `should_stop2`  out  1  sticky: snake 2 head hit something.

## Operation
- Lengths are clamped to MAX_SEG when latched. N = max(clamped len1, clamped len2).
- States: IDLE, SCAN, DONE.
- IDLE, with `start`=1 and `clear`=0:
  - Latch `snake1`, `snake2`, the clamped lengths, and both head positions (slot 0, low POS_W bits).
  - Set index i=0 and clear the pending hit flags `p1` and `p2`.
  - Go to SCAN, or straight to DONE if N=0.
- SCAN, for each index i (one per cycle):
  - `p1` is set if i < len2 and head1 == snake2[i] position.
  - `p2` is set if i < len1 and head2 == snake1[i] position.
  - At i = N-1, go to DONE; otherwise increment i.
- Head-on collision is covered by i=0: if both heads are equal and both lengths are at least 1, both `p1` and `p2` are set.
- Only the POS_W low bits of each slot are compared. The upper SEG_W-POS_W bits are ignored.
- On entry to DONE (registered on the same edge):
  - `done`<=1.
  - `should_stop1` <= `should_stop1` | `p1`.
  - `should_stop2` <= `should_stop2` | `p2`.
- DONE always returns to IDLE on the next cycle.
- The stop flags are sticky; only `clear` or `rst` lowers them.
- `start` is ignored outside IDLE; it is neither queued nor counted.
- `clear`:
  - Forces IDLE, zeroes i, `p1`, `p2` and both stop flags, and suppresses `done`.
  - It beats `start` in the same cycle.
- Input changes during a scan have no effect, because the scan works on the latched snapshot.

## Timing
- Reset values: `busy`=0, `done`=0, `should_stop1`=0, `should_stop2`=0, state IDLE, i=0.
- With `start` sampled at edge T:
  - `busy`=1 for cycles T+1 .. T+N.
  - `done`=1 and updated stop flags are visible in cycle T+N+1.
  - Back in IDLE at T+N+2.
- If N=0, `done` pulses in cycle T+1 and `busy` never rises.
- The earliest next accepted `start` is sampled at edge T+N+2. A `start` held high continuously rescans every N+2 cycles.
- `rst` or `clear` in mid-scan takes effect at the next edge: the following cycle has `busy`=0, `done`=0 and the flags cleared.

## Configuration
- `SNAKE_SELF_COLLISION_EN` defined:
  - Adds self checks during SCAN: `p1` is also set if 1 ≤ i < len1 and head1 == snake1[i].
  - Likewise `p2` is also set if 1 ≤ i < len2 and head2 == snake2[i].
  - Slot 0 is never compared against its own head.
- Not defined:
  - Only cross-snake checks are performed.
  - A snake overlapping itself never raises its own stop flag.
  - No self-comparison logic is instantiated.

## Test plan
- Heads apart: len1=3, len2=3, snake1 positions {5,4,3}, snake2 {20,21,22}, `start` pulse.
  - Required: `busy` for 3 cycles, `done` at T+4, both stop flags stay 0.
- Body hit: len1=2 {7,8}, len2=4 {30,31,7,33}, `start`.
  - Required: `should_stop1`=1 at T+5 and `should_stop2`=0.
  - Flags stay set after a second clean scan, until a `clear` pulse returns both to 0.
- Head-on and N=0:
  - Both heads = 12, lengths 1/1: both flags set at T+2.
  - len1=len2=0: `done` at T+1, `busy` never 1, no flag change.
- Mid-scan events:
  - `start` re-asserted during SCAN is ignored.
  - Changing `snake2` during SCAN does not alter the result.
  - `clear` at scan cycle 2 gives no `done`, flags 0, and IDLE next cycle.
- Clamp and self-check:
  - len1=31 scans 16 indices (`done` at T+17).
  - Snake1 {9,10,9} with the macro defined → `should_stop1`=1.
  - The same stimulus without the macro → `should_stop1`=0.
- Upper-bit masking: slots differing only in bits above POS_W (e.g. 0x0405 vs 0x0005) count as a hit.
